nibble_serial_adder32: RTL and testbench



---
 rtl/nibble_serial_adder32_if.sv | 26 ++
 rtl/nibble_serial_adder32.sv | 119 +++++++++++
 tb/tb_nibble_serial_adder32.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder32_if.sv
// Start/done handshake bundle for the nibble-serial adder: operands in,
// registered result and flags out.
interface nibble_serial_adder32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             overflow;
  logic             zero;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, c_out, overflow, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, c_out, overflow, zero
  );
endinterface

// File: rtl/nibble_serial_adder32.sv
// Multi-cycle adder/subtractor: one 4-bit carry-lookahead slice per clock,
// chained through a carry register, with carry/overflow/zero flags.
module nibble_serial_adder32 #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst_n,
  nibble_serial_adder32_if.slave bus
);
  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int MSB   = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_g;
  logic [3:0]       nib_p;
  logic [3:0]       nib_c;
  logic [3:0]       nib_sum;
  logic             nib_cout;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] result_q;
  logic             c_out_q;
  logic             overflow_q;
  logic             zero_q;

  assign nib_a  = op_a[4*idx +: 4];
  assign nib_b  = op_b[4*idx +: 4];
  assign last   = (idx == IDX_W'(N - 1));
  assign accept = bus.start && (state == IDLE || state == DONE);

  // Carry-lookahead slice: every internal carry comes straight from g/p and carry-in.
  always_comb begin
    nib_g    = nib_a & nib_b;
    nib_p    = nib_a ^ nib_b;
    nib_c[0] = carry;
    nib_c[1] = nib_g[0] | (nib_p[0] & carry);
    nib_c[2] = nib_g[1] | (nib_p[1] & nib_g[0]) | (nib_p[1] & nib_p[0] & carry);
    nib_c[3] = nib_g[2] | (nib_p[2] & nib_g[1]) | (nib_p[2] & nib_p[1] & nib_g[0])
             | (nib_p[2] & nib_p[1] & nib_p[0] & carry);
    nib_cout = nib_g[3] | (nib_p[3] & nib_g[2]) | (nib_p[3] & nib_p[2] & nib_g[1])
             | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0])
             | (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & carry);
    nib_sum  = nib_p ^ nib_c;
  end

  always_comb begin
    acc_next              = acc;
    acc_next[4*idx +: 4]  = nib_sum;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = bus.start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Subtraction folds into the add as a + ~b + 1, with the +1 entering as carry-in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      acc        <= '0;
      carry      <= 1'b0;
      idx        <= '0;
      result_q   <= '0;
      c_out_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else if (accept) begin
      op_a  <= bus.a;
      op_b  <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.sub;
      idx   <= '0;
      acc   <= '0;
    end else if (state == RUN) begin
      acc   <= acc_next;
      carry <= nib_cout;
      if (!last) idx <= idx + IDX_W'(1);
      if (last) begin
        result_q   <= acc_next;
        c_out_q    <= nib_cout;
        overflow_q <= (op_a[MSB] == op_b[MSB]) && (nib_sum[3] != op_a[MSB]);
        zero_q     <= (acc_next == '0);
      end
    end
  end

  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);
  assign bus.result   = result_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = overflow_q;
  assign bus.zero     = zero_q;
endmodule

// File: tb/tb_nibble_serial_adder32.sv
// Self-checking bench for nibble_serial_adder32: directed corner cases plus a
// randomized back-to-back regression against an arithmetic reference model.
module tb_nibble_serial_adder32;
  localparam int WIDTH = 32;
  localparam int N     = WIDTH / 4;
  localparam int NOPS  = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  nibble_serial_adder32_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_adder32 #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference: plain two's-complement arithmetic with a 33-bit sum.
  task automatic refModel(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [31:0] r, output logic c, output logic ov, output logic z);
    logic [32:0] full;
    if (s) full = {1'b0, a} - {1'b0, b} + 33'h1_0000_0000;
    else   full = {1'b0, a} + {1'b0, b};
    r  = full[31:0];
    c  = full[32];
    if (s) ov = (a[31] != b[31]) && (r[31] != a[31]);
    else   ov = (a[31] == b[31]) && (r[31] != a[31]);
    z  = (r == 32'h0);
  endtask

  task automatic checkResult(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] r;
    logic        c, ov, z;
    refModel(a, b, s, r, c, ov, z);
    checkOutput({tag, "_result"}, bus.result, r);
    checkOutput({tag, "_c_out"}, 32'(bus.c_out), 32'(c));
    checkOutput({tag, "_overflow"}, 32'(bus.overflow), 32'(ov));
    checkOutput({tag, "_zero"}, 32'(bus.zero), 32'(z));
  endtask

  // Drive an operation and return just after its accept edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.a     = a;
    bus.b     = b;
    bus.sub   = s;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Counts edges until done, plus busy samples starting with the accept sample.
  task automatic waitDone(output int cycles, output int busy_cycles);
    cycles      = 0;
    busy_cycles = bus.busy ? 1 : 0;
    while (!bus.done && cycles < 4 * N) begin
      @(posedge clk);
      #1;
      cycles++;
      if (bus.busy) busy_cycles++;
    end
  endtask

  task automatic runSingle(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s);
    int cycles, busy_cycles;
    applyStimulus(a, b, s);
    bus.start = 1'b0;
    waitDone(cycles, busy_cycles);
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(N));
    checkOutput({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(N));
    checkResult(tag, a, b, s);
  endtask

  initial begin
    int          cycles, busy_cycles, done_seen;
    logic [31:0] cur_a, cur_b, nxt_a, nxt_b;
    logic        cur_s, nxt_s;

    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(bus.busy), 32'h0);
    checkOutput("rst_done", 32'(bus.done), 32'h0);
    checkOutput("rst_result", bus.result, 32'h0);
    checkOutput("rst_flags", {29'h0, bus.c_out, bus.overflow, bus.zero}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    runSingle("add_wrap", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    checkOutput("add_wrap_const", {bus.result[30:0], bus.c_out}, 32'h0000_0001);
    checkOutput("add_wrap_zero", 32'(bus.zero), 32'h1);
    @(posedge clk);
    #1;
    checkOutput("done_pulse_len", 32'(bus.done), 32'h0);
    checkOutput("idle_hold_result", bus.result, 32'h0);

    runSingle("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    checkOutput("add_ovf_const", bus.result, 32'h8000_0000);
    checkOutput("add_ovf_flag", 32'(bus.overflow), 32'h1);

    runSingle("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b1);
    checkOutput("sub_neg_const", bus.result, 32'hFFFF_FFFE);
    checkOutput("sub_neg_borrow", 32'(bus.c_out), 32'h0);

    runSingle("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1);
    checkOutput("sub_ovf_const", bus.result, 32'h7FFF_FFFF);
    checkOutput("sub_ovf_flags", {30'h0, bus.c_out, bus.overflow}, 32'h3);

    // Inputs and a start pulse during RUN must not disturb the latched operation.
    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.a     = 32'hFFFF_FFFF;
    bus.b     = 32'hFFFF_FFFF;
    bus.sub   = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checkOutput("run_start_ignored_busy", 32'(bus.busy), 32'h1);
    bus.a     = 32'h0F0F_0F0F;
    bus.b     = 32'h0101_0101;
    bus.sub   = 1'b0;
    bus.start = 1'b1;
    waitDone(cycles, busy_cycles);
    checkOutput("immune_result", bus.result, 32'h2345_6789);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checkOutput("b2b_busy_no_idle", 32'(bus.busy), 32'h1);
    checkOutput("b2b_done_low", 32'(bus.done), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("hold_during_run", bus.result, 32'h2345_6789);
    waitDone(cycles, busy_cycles);
    checkOutput("b2b_latency", 32'(cycles), 32'(N - 1));
    checkResult("b2b", 32'h0F0F_0F0F, 32'h0101_0101, 1'b0);

    // Asynchronous reset in the fourth RUN cycle.
    @(posedge clk);
    #1;
    applyStimulus(32'hDEAD_BEEF, 32'h0000_0001, 1'b0);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(bus.busy), 32'h0);
    checkOutput("abort_done", 32'(bus.done), 32'h0);
    checkOutput("abort_result", bus.result, 32'h0);
    checkOutput("abort_flags", {29'h0, bus.c_out, bus.overflow, bus.zero}, 32'h0);
    done_seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.done) done_seen++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) done_seen++;
    end
    checkOutput("abort_no_done", 32'(done_seen), 32'h0);

    runSingle("nib_carry", 32'h0000_000F, 32'h0000_0001, 1'b0);
    checkOutput("nib_carry_const", bus.result, 32'h0000_0010);

    // Randomized regression with start held high: each op chains off the previous done.
    cur_a = $urandom;
    cur_b = $urandom;
    cur_s = 1'($urandom_range(0, 1));
    applyStimulus(cur_a, cur_b, cur_s);
    for (int i = 0; i < NOPS; i++) begin
      nxt_a = $urandom;
      nxt_b = $urandom;
      nxt_s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: nxt_b = nxt_s ? nxt_a : ~nxt_a + 32'h1;
        1: nxt_a = 32'h8000_0000;
        2: nxt_b = 32'h7FFF_FFFF;
        default: ;
      endcase
      bus.a     = nxt_a;
      bus.b     = nxt_b;
      bus.sub   = nxt_s;
      bus.start = (i != NOPS - 1);
      waitDone(cycles, busy_cycles);
      checkOutput("rnd_latency", 32'(cycles), 32'(N));
      checkResult("rnd", cur_a, cur_b, cur_s);
      cur_a = nxt_a;
      cur_b = nxt_b;
      cur_s = nxt_s;
      if (i != NOPS - 1) begin
        @(posedge clk);
        #1;
        checkOutput("rnd_b2b_busy", 32'(bus.busy), 32'h1);
      end
    end
    bus.start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
